mux_4_1: RTL and testbench

- 4-to-1 selector of WIDTH-bit data with a combinational output path and a registered output copy.
- Used wherever one of four sources must be steered onto a single line.
- The combinational path is valid with no clock running; the registered path gives a timing-clean version one cycle later.

---
 rtl/mux_4_1_pkg.sv | 20 ++
 rtl/mux_4_1_core.sv | 34 +++
 rtl/mux_4_1.sv | 49 ++++
 tb/tb_mux_4_1.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/mux_4_1_pkg.sv
// Shared select encoding and decode helper for the 4-to-1 selector.
package mux_4_1_pkg;

  // {s0, s1} encoding: s0 is the MSB of the select index.
  localparam logic [1:0] SEL_I0 = 2'b00;
  localparam logic [1:0] SEL_I1 = 2'b01;
  localparam logic [1:0] SEL_I2 = 2'b10;
  localparam logic [1:0] SEL_I3 = 2'b11;

  function automatic logic [3:0] idx_to_onehot(input logic [1:0] idx);
    case (idx)
      SEL_I0:  idx_to_onehot = 4'b0001;
      SEL_I1:  idx_to_onehot = 4'b0010;
      SEL_I2:  idx_to_onehot = 4'b0100;
      SEL_I3:  idx_to_onehot = 4'b1000;
      default: idx_to_onehot = 4'bxxxx;
    endcase
  endfunction

endpackage

// File: rtl/mux_4_1_core.sv
// Purely combinational 4-to-1 data select with one-hot decode of the index.
module mux_4_1_core
  import mux_4_1_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic [WIDTH-1:0] i0,
  input  logic [WIDTH-1:0] i1,
  input  logic [WIDTH-1:0] i2,
  input  logic [WIDTH-1:0] i3,
  input  logic             s1,
  input  logic             s0,
  output logic [WIDTH-1:0] out,
  output logic [3:0]       sel_oh
);

  logic [1:0] idx;
  assign idx = {s0, s1};

  // An unknown select propagates X rather than quietly picking a source.
  always_comb begin
    // NOTE: every path assigns out, so no latch is inferred for this block.
    case (idx)
      SEL_I0:  out = i0;
      SEL_I1:  out = i1;
      SEL_I2:  out = i2;
      SEL_I3:  out = i3;
      default: out = 'x;
    endcase
  end

  assign sel_oh = idx_to_onehot(idx);

endmodule

// File: rtl/mux_4_1.sv
// 4-to-1 selector: combinational output plus an enabled, registered copy.
module mux_4_1
  import mux_4_1_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i0,
  input  logic [WIDTH-1:0] i1,
  input  logic [WIDTH-1:0] i2,
  input  logic [WIDTH-1:0] i3,
  input  logic             s1,
  input  logic             s0,
  input  logic             en,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] out_q,
  output logic [3:0]       sel_oh
);

  logic [WIDTH-1:0] data_d;
  logic [WIDTH-1:0] data_q;

  mux_4_1_core #(.WIDTH(WIDTH)) u_core (
    .i0     (i0),
    .i1     (i1),
    .i2     (i2),
    .i3     (i3),
    .s1     (s1),
    .s0     (s0),
    .out    (out),
    .sel_oh (sel_oh)
  );

  always_comb begin
    data_d = data_q;
    if (en) data_d = out;
  end

  // Reset is checked first so it overrides a simultaneous enable.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignment keeps the register update ordered after all edge-time reads.
    if (rst) data_q <= '0;
    else     data_q <= data_d;
  end

  assign out_q = data_q;

endmodule

// File: tb/tb_mux_4_1.sv
// Self-checking bench for mux_4_1: directed and random stimulus with a queued out_q scoreboard.
module tb_mux_4_1;

  logic       clk = 1'b0;
  logic       clk_run = 1'b0;
  logic       rst, en;

  // WIDTH=8 instance
  logic [7:0] a0, a1, a2, a3;
  logic       s0, s1;
  logic [7:0] out8, outq8;
  logic [3:0] oh8;

  // WIDTH=1 instance
  logic       b0, b1, b2, b3;
  logic       bs0, bs1;
  logic       bout, boutq;
  logic [3:0] boh;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];
  logic [7:0] model_q;

  mux_4_1 #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .i0(a0), .i1(a1), .i2(a2), .i3(a3),
    .s1(s1), .s0(s0), .en(en), .out(out8), .out_q(outq8), .sel_oh(oh8)
  );

  mux_4_1 #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .i0(b0), .i1(b1), .i2(b2), .i3(b3),
    .s1(bs1), .s0(bs0), .en(en), .out(bout), .out_q(boutq), .sel_oh(boh)
  );

  initial begin
    wait (clk_run);
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: the selected source is simply entry {s0,s1} of the source array.
  function automatic int sel_index(input logic m, input logic l);
    return (m ? 2 : 0) + (l ? 1 : 0);
  endfunction

  // Combinational cases on the 1-bit instance: pick source k; 'hot' is its value, others get ~hot.
  task automatic comb_case(input int k, input logic hot);
    logic [3:0] v;
    for (int n = 0; n < 4; n++) v[n] = (n == k) ? hot : ~hot;
    {b3, b2, b1, b0} = v;
    bs0 = (k >= 2);
    bs1 = (k % 2 == 1);
    #5;
    check($sformatf("w1_out_sel%0d_v%0d", k, hot), {31'd0, bout}, {31'd0, hot});
    check($sformatf("w1_oh_sel%0d", k), {28'd0, boh}, 32'd1 << k);
  endtask

  // One clocked step on the 8-bit instance; pushes the out_q expected after the coming edge.
  task automatic drive_cycle(input logic r, input logic e, input int k,
                             input logic [7:0] d0, input logic [7:0] d1,
                             input logic [7:0] d2, input logic [7:0] d3);
    logic [7:0] src[4];
    @(negedge clk);
    src[0] = d0; src[1] = d1; src[2] = d2; src[3] = d3;
    rst = r; en = e;
    a0 = d0; a1 = d1; a2 = d2; a3 = d3;
    s0 = (k >= 2);
    s1 = (k % 2 == 1);
    #1;
    check("w8_out", {24'd0, out8}, {24'd0, src[sel_index(s0, s1)]});
    check("w8_oh", {28'd0, oh8}, 32'd1 << sel_index(s0, s1));
    if (r)      model_q = 8'h00;
    else if (e) model_q = src[k];
    exp_q.push_back(model_q);
  endtask

  // Monitor: out_q is compared shortly after every edge that has an expectation queued.
  initial begin
    logic [7:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("w8_out_q", {24'd0, outq8}, {24'd0, e});
      end
    end
  end

  initial begin
    rst = 1'b0; en = 1'b0;
    a0 = '0; a1 = '0; a2 = '0; a3 = '0; s0 = 1'b0; s1 = 1'b0;
    model_q = 8'h00;

    // Combinational path with no clock running.
    for (int k = 0; k < 4; k++) comb_case(k, 1'b1);
    for (int k = 0; k < 4; k++) comb_case(k, 1'b0);

    clk_run = 1'b1;

    // Reset, then step the select with enable high.
    drive_cycle(1'b1, 1'b0, 0, 8'hA1, 8'hB2, 8'hC3, 8'hD4);
    drive_cycle(1'b1, 1'b1, 1, 8'hA1, 8'hB2, 8'hC3, 8'hD4);
    for (int k = 0; k < 4; k++) drive_cycle(1'b0, 1'b1, k, 8'hA1, 8'hB2, 8'hC3, 8'hD4);

    // Load C3, then hold it with enable low while the select moves to 3.
    drive_cycle(1'b0, 1'b1, 2, 8'hA1, 8'hB2, 8'hC3, 8'hD4);
    drive_cycle(1'b0, 1'b0, 3, 8'hA1, 8'hB2, 8'hC3, 8'hD4);
    drive_cycle(1'b0, 1'b0, 3, 8'hA1, 8'hB2, 8'hC3, 8'hD4);

    // Reset together with enable: reset wins; next enabled edge reloads.
    drive_cycle(1'b1, 1'b1, 3, 8'hA1, 8'hB2, 8'hC3, 8'hD4);
    drive_cycle(1'b0, 1'b1, 1, 8'hA1, 8'hB2, 8'hC3, 8'hD4);

    // Random phase.
    for (int c = 0; c < 300; c++) begin
      drive_cycle(($urandom_range(0, 15) == 0), 1'($urandom_range(0, 1)),
                  int'($urandom_range(0, 3)),
                  8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
    end

    @(negedge clk);
    en = 1'b0;
    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
    #2;
    check("scoreboard_drain", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
